// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci XNOR LFSR word generator with valid/ready output,
// all-ones seed correction, advance counter and period-completion pulse.
module lfsr_gen #(
    parameter int          WIDTH = 64,
    parameter logic [63:0] TAPS  = 64'hD800_0000_0000_0000,
    parameter int          STEP  = 1,
    parameter int          CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup_fixed,
    output logic [CNT_W-1:0] word_count,
    output logic             period_hit
);
    localparam logic [WIDTH-1:0] TM = TAPS[WIDTH-1:0];
    logic [WIDTH-1:0] state, start, nxt, ld;
    logic adv, lock;
    always_comb begin
        nxt = state;
        for (int i = 0; i < STEP; i++) nxt = {nxt[WIDTH-2:0], ~^(nxt & TM)};
    end
    // all-ones is the XNOR lockup state; clearing bit0 puts the seed back on the cycle
    assign lock = &seed;
    assign ld = lock ? {seed[WIDTH-1:1], 1'b0} : seed;
    assign adv = enable & out_valid & out_ready & ~seed_load;
    assign out_data = state;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '0;
            start <= '0;
            out_valid <= 1'b0;
            word_count <= '0;
            lockup_fixed <= 1'b0;
            period_hit <= 1'b0;
        end else if (seed_load) begin
            state <= ld;
            start <= ld;
            out_valid <= 1'b1;
            word_count <= '0;
            lockup_fixed <= lock;
            period_hit <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            lockup_fixed <= 1'b0;
            period_hit <= adv && nxt == start;
            if (adv) begin
                state <= nxt;
                word_count <= word_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: three lfsr_gen configurations driven in lockstep and checked
// against directed constants and a parity-based reference model.
module tb_lfsr_gen;
    logic clk = 0, rst_n = 0, seed_load = 0, enable = 0, out_ready = 0;
    logic [15:0] seed = '0;
    logic a_valid, a_lock, a_hit, b_valid, b_lock, b_hit, c_valid, c_lock, c_hit;
    logic [15:0] a_data, b_data;
    logic [3:0] c_data;
    logic [31:0] a_cnt, b_cnt, c_cnt;
    int checks = 0, errors = 0;

    int W[3] = '{16, 16, 4};
    int S[3] = '{1, 4, 1};
    logic [63:0] T[3] = '{64'hD008, 64'hD008, 64'hC};
    logic [63:0] ms[3], mst[3];
    logic [31:0] mc[3];
    logic mv[3], ml[3], mh[3];

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(16), .TAPS(64'hD008), .STEP(1), .CNT_W(32)) ua (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .enable(enable),
        .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data), .lockup_fixed(a_lock),
        .word_count(a_cnt), .period_hit(a_hit));
    lfsr_gen #(.WIDTH(16), .TAPS(64'hD008), .STEP(4), .CNT_W(32)) ub (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .enable(enable),
        .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data), .lockup_fixed(b_lock),
        .word_count(b_cnt), .period_hit(b_hit));
    lfsr_gen #(.WIDTH(4), .TAPS(64'hC), .STEP(1), .CNT_W(32)) uc (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed[3:0]), .enable(enable),
        .out_ready(out_ready), .out_valid(c_valid), .out_data(c_data), .lockup_fixed(c_lock),
        .word_count(c_cnt), .period_hit(c_hit));

    // XNOR feedback is 1 exactly when the tapped bits hold an even number of ones
    function automatic logic [63:0] lfsr(logic [63:0] s, int w, logic [63:0] taps, int n);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        for (int i = 0; i < n; i++)
            s = ((s << 1) | (($countones(s & taps & m) % 2 == 0) ? 64'd1 : 64'd0)) & m;
        return s;
    endfunction

    task automatic tick();
        logic [63:0] m, sd;
        for (int k = 0; k < 3; k++) begin
            m = (64'd1 << W[k]) - 64'd1;
            sd = {48'd0, seed} & m;
            if (!rst_n) begin
                ms[k] = 0; mst[k] = 0; mv[k] = 0; mc[k] = 0; ml[k] = 0; mh[k] = 0;
            end else if (seed_load) begin
                ml[k] = (sd == m);
                if (sd == m) sd = m & ~64'd1;
                ms[k] = sd; mst[k] = sd; mc[k] = 0; mh[k] = 0; mv[k] = 1;
            end else begin
                ml[k] = 0; mh[k] = 0;
                if (enable && mv[k] && out_ready) begin
                    ms[k] = lfsr(ms[k], W[k], T[k], S[k]);
                    mc[k] = mc[k] + 1;
                    mh[k] = (ms[k] == mst[k]);
                end
                mv[k] = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; seed_load = 0; enable = 0; out_ready = 0;
        tick(); tick();
        checks++;
        if ({a_valid, a_lock, a_hit, a_cnt, a_data} !== 51'd0) begin
            errors++; $display("FAIL reset_a: got v%b l%b h%b c%0d d%h want all zero", a_valid, a_lock, a_hit, a_cnt, a_data);
        end
        checks++;
        if ({c_valid, c_data, c_cnt} !== 37'd0) begin
            errors++; $display("FAIL reset_c: got v%b c%0d d%h want all zero", c_valid, c_cnt, c_data);
        end
        rst_n = 1;
        tick();
        checks++;
        if (a_valid !== 1'b1 || a_data !== 16'h0) begin
            errors++; $display("FAIL release: got v%b d%h want v1 d0000", a_valid, a_data);
        end
    endtask

    task automatic test_sequence();
        logic [15:0] exp_a[5] = '{16'h1, 16'h3, 16'h7, 16'hF, 16'h1E};
        logic [15:0] exp_b[2] = '{16'h000F, 16'h00F0};
        enable = 1; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_data !== exp_a[i]) begin
                errors++; $display("FAIL seq_a[%0d]: got %h want %h", i, a_data, exp_a[i]);
            end
            if (i < 2) begin
                checks++;
                if (b_data !== exp_b[i]) begin
                    errors++; $display("FAIL step4_b[%0d]: got %h want %h", i, b_data, exp_b[i]);
                end
            end
        end
        checks++;
        if (a_cnt !== 32'd5) begin
            errors++; $display("FAIL seq_count: got %0d want 5", a_cnt);
        end
        checks++;
        if (c_data !== ms[2][3:0]) begin
            errors++; $display("FAIL seq_c: got %h want %h", c_data, ms[2][3:0]);
        end
    endtask

    task automatic test_backpressure();
        rst_n = 0; tick();
        rst_n = 1; out_ready = 0; enable = 1; tick();
        out_ready = 1;
        tick(); tick(); tick();
        checks++;
        if (a_data !== 16'h7) begin
            errors++; $display("FAIL bp_pre: got %h want 0007", a_data);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) out_ready = 0; else enable = 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++;
                if (a_data !== (pass == 0 ? 16'h7 : 16'hF) || a_cnt !== 32'(3 + pass) || a_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_hold[%0d.%0d]: got d%h c%0d v%b", pass, i, a_data, a_cnt, a_valid);
                end
            end
            out_ready = 1; enable = 1;
            tick();
            checks++;
            if (a_data !== (pass == 0 ? 16'hF : 16'h1E)) begin
                errors++; $display("FAIL bp_resume[%0d]: got %h want %h", pass, a_data, pass == 0 ? 16'hF : 16'h1E);
            end
        end
    endtask

    task automatic test_lockup();
        enable = 1; out_ready = 1; seed = 16'hFFFF; seed_load = 1;
        tick();
        seed_load = 0; out_ready = 0;
        checks++;
        if (a_data !== 16'hFFFE || a_lock !== 1'b1 || a_cnt !== 32'd0 || a_hit !== 1'b0) begin
            errors++; $display("FAIL lock_a: got d%h l%b c%0d h%b want dFFFE l1 c0 h0", a_data, a_lock, a_cnt, a_hit);
        end
        checks++;
        if (b_data !== 16'hFFFE || c_data !== 4'hE || c_lock !== 1'b1) begin
            errors++; $display("FAIL lock_bc: got b%h c%h cl%b want bFFFE cE cl1", b_data, c_data, c_lock);
        end
        tick();
        checks++;
        if (a_lock !== 1'b0 || a_data !== 16'hFFFE) begin
            errors++; $display("FAIL lock_pulse: got l%b d%h want l0 dFFFE", a_lock, a_data);
        end
        seed = 16'hACE1; seed_load = 1;
        tick();
        seed_load = 0;
        checks++;
        if (a_data !== 16'hACE1 || a_lock !== 1'b0 || b_data !== 16'hACE1 || c_data !== 4'h1) begin
            errors++; $display("FAIL seed_ace1: got a%h l%b b%h c%h want ACE1 0 ACE1 1", a_data, a_lock, b_data, c_data);
        end
    endtask

    task automatic test_period();
        seed = 16'h0; seed_load = 1;
        tick();
        seed_load = 0; out_ready = 1; enable = 1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            checks++;
            if (c_hit !== (k % 15 == 0) || c_cnt !== 32'(k) || c_data === 4'hF || c_data !== ms[2][3:0]) begin
                errors++; $display("FAIL period[%0d]: got h%b c%0d d%h want h%b c%0d d%h", k, c_hit, c_cnt, c_data, k % 15 == 0, k, ms[2][3:0]);
            end
        end
        checks++;
        if (a_hit !== 1'b0) begin
            errors++; $display("FAIL period_a: got %b want 0", a_hit);
        end
    endtask

    task automatic test_midreset();
        rst_n = 0; tick();
        rst_n = 1; out_ready = 0; tick();
        out_ready = 1; enable = 1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (a_cnt !== 32'd7) begin
            errors++; $display("FAIL mid_pre: got %0d want 7", a_cnt);
        end
        rst_n = 0; tick();
        checks++;
        if (a_valid !== 1'b0 || a_data !== 16'h0 || a_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_rst: got v%b d%h c%0d want v0 d0 c0", a_valid, a_data, a_cnt);
        end
        rst_n = 1; tick();
        checks++;
        if (a_valid !== 1'b1 || a_data !== 16'h0) begin
            errors++; $display("FAIL mid_rel: got v%b d%h want v1 d0", a_valid, a_data);
        end
        tick();
        checks++;
        if (a_data !== 16'h1) begin
            errors++; $display("FAIL mid_adv: got %h want 0001", a_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom % 64) != 0;
            seed_load = ($urandom % 12) == 0;
            seed = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
            enable = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            tick();
            checks++;
            if ({a_valid, a_lock, a_hit, a_cnt, a_data} !== {mv[0], ml[0], mh[0], mc[0], ms[0][15:0]}) begin
                errors++; $display("FAIL rand_a[%0d]: got v%b l%b h%b c%0d d%h want v%b l%b h%b c%0d d%h", i,
                    a_valid, a_lock, a_hit, a_cnt, a_data, mv[0], ml[0], mh[0], mc[0], ms[0][15:0]);
            end
            checks++;
            if ({b_valid, b_lock, b_hit, b_cnt, b_data} !== {mv[1], ml[1], mh[1], mc[1], ms[1][15:0]}) begin
                errors++; $display("FAIL rand_b[%0d]: got v%b l%b h%b c%0d d%h want v%b l%b h%b c%0d d%h", i,
                    b_valid, b_lock, b_hit, b_cnt, b_data, mv[1], ml[1], mh[1], mc[1], ms[1][15:0]);
            end
            checks++;
            if ({c_valid, c_lock, c_hit, c_cnt, c_data} !== {mv[2], ml[2], mh[2], mc[2], ms[2][3:0]}) begin
                errors++; $display("FAIL rand_c[%0d]: got v%b l%b h%b c%0d d%h want v%b l%b h%b c%0d d%h", i,
                    c_valid, c_lock, c_hit, c_cnt, c_data, mv[2], ml[2], mh[2], mc[2], ms[2][3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_lockup();
        test_period();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
